// File: rtl/xof_finalize_arbiter.sv
// Round-robin arbiter sharing one keccak_finalize core between a SHAKE128 and
// a SHAKE256 requester. Requests whose absorb position already reaches the
// rate are rejected without touching the core.
module xof_finalize_arbiter #(
   parameter int unsigned RATE128 = 168,
   parameter int unsigned RATE256 = 136,
   parameter logic [7:0]  PAD_P   = 8'd31
) (
   input  logic            clock,
   input  logic            reset,
   // SHAKE128 requester
   input  logic            req128_valid,
   input  logic [1599:0]   req128_s_in,
   input  logic [31:0]     req128_pos_in,
   output logic            req128_ready,
   output logic            done128,
   // SHAKE256 requester
   input  logic            req256_valid,
   input  logic [1599:0]   req256_s_in,
   input  logic [31:0]     req256_pos_in,
   output logic            req256_ready,
   output logic            done256,
   // Shared response
   output logic [1599:0]   resp_s_out,
   output logic [31:0]     resp_pos_out,
   output logic            resp_err,
   // Shared keccak_finalize core
   output logic            core_start,
   output logic [1599:0]   core_s_in,
   output logic [31:0]     core_pos,
   output logic [31:0]     core_r,
   output logic [7:0]      core_p,
   input  logic [1599:0]   core_s_out,
   input  logic            core_done
);

   localparam logic [31:0] Rate128W = 32'(RATE128);
   localparam logic [31:0] Rate256W = 32'(RATE256);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e state_q;
   // Variant of the transaction in flight: 0 = SHAKE128, 1 = SHAKE256
   logic   var_q;
   // Variant served most recently; reset to SHAKE256 so SHAKE128 wins first tie
   logic   last_q;

   logic            grant128;
   logic            grant256;
   logic            accept;
   logic            reject;
   logic [1599:0]   sel_s;
   logic [31:0]     sel_pos;
   logic [31:0]     sel_rate;

   // Round-robin grant, only offered while idle and only to a valid requester
   always_comb begin
      grant128 = 1'b0;
      grant256 = 1'b0;
      if (state_q == StIdle) begin
         if (req128_valid && req256_valid) begin
            grant256 = (last_q == 1'b0);
            grant128 = ~grant256;
         end else begin
            grant128 = req128_valid;
            grant256 = req256_valid;
         end
      end
   end

   assign req128_ready = grant128;
   assign req256_ready = grant256;

   // Select the granted request; a grant always implies valid, so grant == accept
   always_comb begin
      accept   = grant128 | grant256;
      sel_s    = grant256 ? req256_s_in   : req128_s_in;
      sel_pos  = grant256 ? req256_pos_in : req128_pos_in;
      sel_rate = grant256 ? Rate256W      : Rate128W;
      reject   = (sel_pos >= sel_rate);
   end

   // Transaction FSM with registered core and response outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         var_q        <= 1'b0;
         last_q       <= 1'b1;
         core_start   <= 1'b0;
         core_s_in    <= '0;
         core_pos     <= '0;
         core_r       <= '0;
         core_p       <= '0;
         done128      <= 1'b0;
         done256      <= 1'b0;
         resp_s_out   <= '0;
         resp_pos_out <= '0;
         resp_err     <= 1'b0;
      end else begin
         core_start <= 1'b0;
         done128    <= 1'b0;
         done256    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  // Core operands stay frozen here until the next accept
                  core_s_in <= sel_s;
                  core_pos  <= sel_pos;
                  core_r    <= sel_rate;
                  core_p    <= PAD_P;
                  var_q     <= grant256;
                  if (reject) begin
                     // Nothing to pad: hand the state straight back flagged
                     resp_s_out   <= sel_s;
                     resp_pos_out <= sel_rate;
                     resp_err     <= 1'b1;
                     done128      <= ~grant256;
                     done256      <= grant256;
                     state_q      <= StResp;
                  end else begin
                     core_start <= 1'b1;
                     state_q    <= StIssue;
                  end
               end
            end
            StIssue: begin
               state_q <= StWait;
            end
            StWait: begin
               if (core_done) begin
                  resp_s_out   <= core_s_out;
                  resp_pos_out <= core_r;
                  resp_err     <= 1'b0;
                  done128      <= ~var_q;
                  done256      <= var_q;
                  state_q      <= StResp;
               end
            end
            StResp: begin
               last_q  <= var_q;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // Never offer both requesters at once
   a_ready_onehot : assert property (@(posedge clock) disable iff (!reset)
      !(req128_ready && req256_ready));
   // A start only ever accompanies the issue state
   a_start_issue : assert property (@(posedge clock) disable iff (!reset)
      core_start |-> (state_q == StIssue));
   // Start and done are single-cycle pulses
   a_start_pulse : assert property (@(posedge clock) disable iff (!reset)
      core_start |=> !core_start);
   a_done_pulse : assert property (@(posedge clock) disable iff (!reset)
      (done128 || done256) |=> !(done128 || done256));
`endif

endmodule

// File: doc/xof_finalize_arbiter.md
XOF_FINALIZE_ARBITER -- requirements
Module: xof_finalize_arbiter

Interface
REQ-001 SHALL have parameter RATE128, default 168, SHAKE128 rate in bytes.
REQ-002 SHALL have parameter RATE256, default 136, SHAKE256 rate in bytes.
REQ-003 SHALL have parameter PAD_P, default 8'd31, SHAKE domain/padding byte.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req128_valid / req256_valid  input  1  finalize request, SHAKE128 / SHAKE256.
REQ-007 SHALL have ports req128_s_in / req256_s_in  input  1600  Keccak state to finalize.
REQ-008 SHALL have ports req128_pos_in / req256_pos_in  input  32  absorb position in bytes.
REQ-009 SHALL have ports req128_ready / req256_ready  output  1  request accepted this cycle when high with valid.
REQ-010 SHALL have ports done128 / done256  output  1  one-cycle completion pulse per requester.
REQ-011 SHALL have port resp_s_out  output  1600  finalized state, valid with done pulse.
REQ-012 SHALL have port resp_pos_out  output  32  rate of served variant, valid with done pulse.
REQ-013 SHALL have port resp_err  output  1  qualifies done pulse; request rejected.
REQ-014 SHALL have ports core_start  output  1; core_s_in  output  1600; core_pos  output  32; core_r  output  32; core_p  output  8  drive shared keccak_finalize.
REQ-015 SHALL have ports core_s_out  input  1600; core_done  input  1  results from shared keccak_finalize.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 SHALL, in IDLE, assert ready only to the granted requester, combinationally, while its valid is high; accept on valid&&ready.
REQ-018 SHALL grant by round-robin: single requester wins; if both valid, grant the variant not served last; after reset SHAKE128 wins the first tie.
REQ-019 SHALL on accept latch s_in, pos_in, variant; core_r = RATE128 or RATE256 per variant, core_p = PAD_P; go to ISSUE.
REQ-020 SHALL, when latched pos_in >= selected rate, skip the core, go directly to RESP with resp_err=1, resp_s_out = latched s_in.
REQ-021 SHALL in ISSUE assert core_start for exactly one cycle, then go to WAIT.
REQ-022 SHALL hold core_s_in/core_pos/core_r/core_p stable from ISSUE until core_done.
REQ-023 SHALL in WAIT, on core_done, register core_s_out into resp_s_out, set resp_pos_out = selected rate, resp_err=0; go to RESP.
REQ-024 SHALL ignore core_done in IDLE, ISSUE, RESP.
REQ-025 SHALL in RESP pulse done128 or done256 (matching variant) for one cycle, update last-served, return to IDLE.
REQ-026 SHALL hold resp_s_out/resp_pos_out/resp_err until the next RESP.
REQ-027 SHALL deassert both ready outputs outside IDLE; requests held valid are served after return to IDLE.
REQ-028 SHALL add minimum latency: accept to done = 2 cycles + core latency (core_done cycle to done pulse = 1 cycle); rejected request: accept to done = 1 cycle.
REQ-029 SHALL never issue a second core_start before core_done of the previous one.

Reset
REQ-030 SHALL on reset low asynchronously enter IDLE, clear core_start, done128, done256, resp_err, resp_s_out, resp_pos_out, core_s_in, core_pos, core_r, core_p to 0, last-served to SHAKE256.
REQ-031 SHALL on reset mid-transaction abandon it with no done pulse; core_done arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-032 SHALL cover: req128 alone, pos_in=5, core_done 24 cycles after start -> one core_start, core_r=168, core_p=31, done128 pulse, resp_pos_out=168, resp_err=0, resp_s_out=core_s_out.
REQ-033 SHALL cover: both valid from reset -> SHAKE128 served first, then SHAKE256 with core_r=136; next tie grants SHAKE128.
REQ-034 SHALL cover: req256 pos_in=136 -> no core_start, done256 one cycle after accept, resp_err=1, resp_s_out=req256_s_in.
REQ-035 SHALL cover: spurious core_done in IDLE and during RESP -> no state change, no done pulse.
REQ-036 SHALL cover: reset asserted in WAIT -> outputs zero immediately, no done; after release, new req256 completes normally.
